// File: rtl/ula_pkg.sv
// Shared encodings for the ULA result-bus reader: source selects, last-source
// tracking, FSM states and the per-source enable decode.
package ula_pkg;

    localparam int unsigned WIDTH_DEFAULT = 8;

    localparam logic [1:0] SRC_LOGIC   = 2'd0;
    localparam logic [1:0] SRC_ARITH   = 2'd1;
    localparam logic [1:0] SRC_NOCARRY = 2'd2;
    localparam logic [1:0] SRC_ILLEGAL = 2'd3;

    // last_src reuses the select encoding; code 3 never owns the bus, so it means NONE
    localparam logic [1:0] SRC_NONE    = 2'd3;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] TURN  = 2'd1;
    localparam logic [1:0] DRIVE = 2'd2;
    localparam logic [1:0] HOLD  = 2'd3;

    // enable vector ordering: {nocarry, arith, logic}
    function automatic logic [2:0] src_enable(input logic [1:0] sel);
        logic [2:0] en;
        en = '0;
        case (sel)
            SRC_LOGIC:   en = 3'b001;
            SRC_ARITH:   en = 3'b010;
            SRC_NOCARRY: en = 3'b100;
            default:     en = '0;
        endcase
        return en;
    endfunction

endpackage

// File: rtl/ula_bus_capture.sv
// Result registers for the ULA bus reader: samples the bus on a capture strobe,
// masks the carry for non-arithmetic sources and derives the zero flag.
module ula_bus_capture
    import ula_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             capture,
    input  logic             capture_err,
    input  logic             carry_en,
    input  logic [WIDTH:0]   bus_in,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic             out_zero,
    output logic             out_err
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_carry <= 1'b0;
            out_zero  <= 1'b0;
            out_err   <= 1'b0;
        end else if (capture_err) begin
            out_data  <= '0;
            out_carry <= 1'b0;
            out_zero  <= 1'b0;
            out_err   <= 1'b1;
        end else if (capture) begin
            out_data  <= bus_in[WIDTH-1:0];
            // bit WIDTH floats unless the arithmetic unit owns the bus
            out_carry <= carry_en & bus_in[WIDTH];
            out_zero  <= (bus_in[WIDTH-1:0] == '0);
            out_err   <= 1'b0;
        end
    end

endmodule

// File: rtl/ula_bus_reader.sv
// Receiving end of the ULA shared result bus: arbitrates one tri-state source at a
// time with a turnaround gap, samples after a settle delay and holds the result.
module ula_bus_reader
    import ula_pkg::*;
#(
    parameter int unsigned WIDTH         = WIDTH_DEFAULT,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    input  logic [1:0]       req_sel,
    output logic             req_ready,
    output logic             en_logic,
    output logic             en_arith,
    output logic             en_nocarry,
    input  logic [WIDTH:0]   bus_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic             out_zero,
    output logic             out_err
);

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);

    logic [1:0] state;
    logic [1:0] sel_q;
    logic [1:0] last_src;
    logic [3:0] cnt;
    logic [2:0] en;
    logic       accept;
    logic       capture;
    logic       capture_err;

    assign req_ready   = (state == IDLE);
    assign out_valid   = (state == HOLD);
    assign accept      = req_valid & req_ready;
    assign capture     = (state == DRIVE) && (cnt == 4'd1);
    assign capture_err = accept && (req_sel == SRC_ILLEGAL);

    assign en_logic   = en[0];
    assign en_arith   = en[1];
    assign en_nocarry = en[2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sel_q    <= SRC_LOGIC;
            last_src <= SRC_NONE;
            cnt      <= '0;
            en       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sel_q <= req_sel;
                        if (req_sel == SRC_ILLEGAL) begin
                            state <= HOLD;
                        end else if (last_src != SRC_NONE && req_sel != last_src) begin
                            state <= TURN;
                        end else begin
                            state <= DRIVE;
                            cnt   <= SETTLE_LD;
                            en    <= src_enable(req_sel);
                        end
                    end
                end
                TURN: begin
                    state <= DRIVE;
                    cnt   <= SETTLE_LD;
                    en    <= src_enable(sel_q);
                end
                DRIVE: begin
                    if (cnt == 4'd1) begin
                        state    <= HOLD;
                        en       <= '0;
                        cnt      <= '0;
                        last_src <= sel_q;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    ula_bus_capture #(
        .WIDTH(WIDTH)
    ) u_capture (
        .clk         (clk),
        .rst_n       (rst_n),
        .capture     (capture),
        .capture_err (capture_err),
        .carry_en    (sel_q == SRC_ARITH),
        .bus_in      (bus_in),
        .out_data    (out_data),
        .out_carry   (out_carry),
        .out_zero    (out_zero),
        .out_err     (out_err)
    );

endmodule

// File: tb/tb_ula_bus_reader.sv
// Directed bench for ula_bus_reader: one instance with SETTLE_CYCLES=1, one with 3.
module tb_ula_bus_reader;

    logic       clk;
    logic       rst_n;

    logic       req_valid, req_ready, out_ready, out_valid;
    logic [1:0] req_sel;
    logic       en_logic, en_arith, en_nocarry;
    logic [8:0] bus;
    logic [7:0] out_data;
    logic       out_carry, out_zero, out_err;

    logic       req_valid3, req_ready3, out_ready3, out_valid3;
    logic [1:0] req_sel3;
    logic       en_logic3, en_arith3, en_nocarry3;
    logic [8:0] bus3;
    logic [7:0] out_data3;
    logic       out_carry3, out_zero3, out_err3;

    logic [7:0] val_logic, val_nc;
    logic [8:0] val_arith;

    int n_checks = 0;
    int n_pass   = 0;

    // Bus model: bit 8 is modelled floating high for 8-bit sources so carry masking is visible
    function automatic logic [8:0] bus_model(input logic el, input logic ea, input logic en_n,
                                             input logic [7:0] vl, input logic [8:0] va,
                                             input logic [7:0] vn);
        if (ea)        return va;
        else if (el)   return {1'b1, vl};
        else if (en_n) return {1'b1, vn};
        else           return 9'h1FF;
    endfunction

    assign bus  = bus_model(en_logic, en_arith, en_nocarry, val_logic, val_arith, val_nc);
    assign bus3 = bus_model(en_logic3, en_arith3, en_nocarry3, 8'h00, 9'h081, 8'h00);

    ula_bus_reader #(
        .WIDTH(8),
        .SETTLE_CYCLES(1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_sel(req_sel), .req_ready(req_ready),
        .en_logic(en_logic), .en_arith(en_arith), .en_nocarry(en_nocarry),
        .bus_in(bus),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_carry(out_carry), .out_zero(out_zero), .out_err(out_err)
    );

    ula_bus_reader #(
        .WIDTH(8),
        .SETTLE_CYCLES(3)
    ) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid3), .req_sel(req_sel3), .req_ready(req_ready3),
        .en_logic(en_logic3), .en_arith(en_arith3), .en_nocarry(en_nocarry3),
        .bus_in(bus3),
        .out_valid(out_valid3), .out_ready(out_ready3),
        .out_data(out_data3), .out_carry(out_carry3), .out_zero(out_zero3), .out_err(out_err3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        check("onehot", 32'($countones({en_logic, en_arith, en_nocarry}) <= 1), 32'd1);
        check("onehot3", 32'($countones({en_logic3, en_arith3, en_nocarry3}) <= 1), 32'd1);
    end

    // Issue one request from IDLE; returns latency (request cycle to out_valid cycle),
    // cycles with all enables low, and cycles with an enable high before out_valid.
    task automatic run_req(input logic [1:0] sel, output int lat, output int zeros,
                           output int ens);
        req_valid = 1'b1;
        req_sel   = sel;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_sel   = ~sel;
        lat = 1; zeros = 0; ens = 0;
        while (!out_valid && lat < 40) begin
            if ({en_logic, en_arith, en_nocarry} == 3'b000) zeros++;
            else ens++;
            @(posedge clk); #1;
            lat++;
        end
        if (lat >= 40) check("timeout", 32'd0, 32'd1);
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("release_valid", 32'(out_valid), 32'd0);
    endtask

    int lat, zeros, ens;

    initial begin
        rst_n = 1'b0;
        req_valid = 0; req_sel = 0; out_ready = 0;
        req_valid3 = 0; req_sel3 = 0; out_ready3 = 0;
        val_logic = 8'h00; val_arith = 9'h000; val_nc = 8'h00;
        #7;
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_en", 32'({en_logic, en_arith, en_nocarry}), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_flags", 32'({out_carry, out_zero, out_err}), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        rst_n = 1'b1;

        // SETTLE_CYCLES = 3 instance: arithmetic source, long HOLD
        @(posedge clk); #1;
        req_valid3 = 1'b1; req_sel3 = 2'd1;
        @(posedge clk); #1;
        req_valid3 = 1'b0; req_sel3 = 2'd0;
        for (int i = 0; i < 3; i++) begin
            check("s3_en_arith", 32'(en_arith3), 32'd1);
            check("s3_novalid", 32'(out_valid3), 32'd0);
            @(posedge clk); #1;
        end
        check("s3_valid", 32'(out_valid3), 32'd1);
        check("s3_en_off", 32'(en_arith3), 32'd0);
        check("s3_result", 32'({out_carry3, out_zero3, out_err3, out_data3}), 32'h081);
        for (int i = 0; i < 5; i++) begin
            check("s3_hold_data", 32'(out_data3), 32'h81);
            check("s3_hold_ready", 32'(req_ready3), 32'd0);
            check("s3_hold_valid", 32'(out_valid3), 32'd1);
            @(posedge clk); #1;
        end
        out_ready3 = 1'b1;
        @(posedge clk); #1;
        out_ready3 = 1'b0;
        check("s3_release_valid", 32'(out_valid3), 32'd0);
        check("s3_release_ready", 32'(req_ready3), 32'd1);
        check("s3_keep_data", 32'(out_data3), 32'h81);

        // First request after reset: arithmetic, no TURN
        val_arith = 9'h100;
        run_req(2'd1, lat, zeros, ens);
        check("arith_lat", lat, 2);
        check("arith_turn", zeros, 0);
        check("arith_en", ens, 1);
        check("arith_result", 32'({out_carry, out_zero, out_err, out_data}), 32'h600);
        check("hold_ready", 32'(req_ready), 32'd0);
        release_out();

        // Source change to logic: one TURN cycle, carry masked
        val_logic = 8'hA5;
        run_req(2'd0, lat, zeros, ens);
        check("logic_lat", lat, 3);
        check("logic_turn", zeros, 1);
        check("logic_en", ens, 1);
        check("logic_result", 32'({out_carry, out_zero, out_err, out_data}), 32'h0A5);
        release_out();

        // Back-to-back no-carry with out_ready held high
        val_nc = 8'h3C;
        out_ready = 1'b1;
        run_req(2'd2, lat, zeros, ens);
        check("nc1_lat", lat, 3);
        check("nc1_data", 32'({out_carry, out_data}), 32'h03C);
        @(posedge clk); #1;
        check("nc1_back_idle", 32'(req_ready), 32'd1);
        run_req(2'd2, lat, zeros, ens);
        check("nc2_lat", lat, 2);
        check("nc2_turn", zeros, 0);
        check("nc2_data", 32'({out_carry, out_zero, out_data}), 32'h03C);
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("nc2_exit", 32'(out_valid), 32'd0);

        // Illegal select
        run_req(2'd3, lat, zeros, ens);
        check("ill_lat", lat, 1);
        check("ill_en", ens, 0);
        check("ill_result", 32'({out_carry, out_zero, out_err, out_data}), 32'h100);
        release_out();
        check("ill_keep_err", 32'(out_err), 32'd1);

        // logic, illegal, arith: illegal leaves last_src alone so TURN still appears
        run_req(2'd0, lat, zeros, ens);
        check("l2_lat", lat, 3);
        release_out();
        run_req(2'd3, lat, zeros, ens);
        check("ill2_lat", lat, 1);
        release_out();
        val_arith = 9'h17F;
        run_req(2'd1, lat, zeros, ens);
        check("a2_lat", lat, 3);
        check("a2_turn", zeros, 1);
        check("a2_result", 32'({out_carry, out_zero, out_err, out_data}), 32'h47F);
        release_out();

        // Reset during DRIVE, then a different source skips TURN
        req_valid = 1'b1; req_sel = 2'd0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rd_turn", 32'({en_logic, en_arith, en_nocarry}), 32'd0);
        @(posedge clk); #1;
        check("rd_drive", 32'(en_logic), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rd_en_off", 32'({en_logic, en_arith, en_nocarry}), 32'd0);
        check("rd_valid", 32'(out_valid), 32'd0);
        check("rd_data", 32'(out_data), 32'd0);
        check("rd_ready", 32'(req_ready), 32'd1);
        #1;
        rst_n = 1'b1;
        run_req(2'd2, lat, zeros, ens);
        check("rd_next_lat", lat, 2);
        check("rd_next_turn", zeros, 0);
        check("rd_next_data", 32'(out_data), 32'h3C);
        release_out();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ula_bus_reader.md
Name: ula_bus_reader

Overview:
- Receiving end of the ULA shared result bus.
- The bus is a 9-bit wire driven by three tri-state sources:
  - logic unit, 8 bits;
  - arithmetic unit, 9 bits including carry;
  - no-carry unit, 8 bits.
- The block accepts a source-select request and drives exactly one enable, with a turnaround gap between different sources.
- It samples the bus after a settle delay and presents a registered result, carry and zero flag on a valid/ready output handshake.

Parameters:
- WIDTH, 8: data width of the result; the bus is WIDTH+1 bits.
- SETTLE_CYCLES, 1: cycles the selected enable is held before sampling; range 1-15.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_sel  in  2  source: 0 = logic, 1 = arithmetic, 2 = no-carry, 3 = illegal.
- req_ready  out  1  block can accept a request.
- en_logic  out  1  enable to the logic tri-state drivers.
- en_arith  out  1  enable to the arithmetic tri-state driver.
- en_nocarry  out  1  enable to the no-carry tri-state driver.
- bus_in  in  WIDTH+1  shared tri-state result bus.
- out_valid  out  1  result registers hold a result.
- out_ready  in  1  consumer accepts the result.
- out_data  out  WIDTH  captured result, bus_in[WIDTH-1:0].
- out_carry  out  1  bus_in[WIDTH] for arithmetic; 0 for other sources.
- out_zero  out  1  1 when out_data == 0.
- out_err  out  1  request had req_sel = 3.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - en_logic, en_arith, en_nocarry, out_valid, out_carry, out_zero, out_err = 0.
  - out_data = 0.
  - req_ready = 1.
  - State = IDLE; last_src = NONE; settle counter = 0.
- Bus ownership:
  - At most one en_* is high in any cycle.
  - All en_* are registered outputs; none are combinational.
- IDLE:
  - req_ready = 1. A request is accepted when req_valid & req_ready.
  - req_sel = 3: go to HOLD next cycle with out_err = 1, out_data = 0, out_carry = 0, out_zero = 0. No enable is asserted and last_src is unchanged.
  - req_sel differs from last_src and last_src != NONE: go to TURN.
  - Otherwise (same source, or first request after reset): go to DRIVE.
- TURN:
  - All enables low for exactly 1 cycle, to avoid contention, then go to DRIVE.
- DRIVE:
  - The selected en_* is high. The counter loads SETTLE_CYCLES and decrements each cycle.
  - When it reaches 1, the block samples bus_in at that clock edge into out_data and out_carry.
  - out_carry = bus_in[WIDTH] only if sel = 1; otherwise forced to 0, because bit WIDTH is undriven.
  - out_zero is computed from the sampled data. out_err = 0. last_src = sel.
  - Next state is HOLD. The enable deasserts in the same cycle HOLD begins.
- HOLD:
  - out_valid = 1 and the out_* signals are stable. req_ready = 0.
  - When out_ready = 1, return to IDLE next cycle with out_valid = 0. out_data and flags keep their values until the next capture.
- Latency from accept to out_valid:
  - Same source: 1 + SETTLE_CYCLES.
  - Source change: 2 + SETTLE_CYCLES.
  - Illegal request: 1.
- Simultaneous events:
  - req_valid is ignored whenever req_ready = 0.
  - out_ready while out_valid = 0 has no effect.
  - No new request is accepted in the cycle HOLD exits (single-entry, no bypass).
- Reset mid-operation (any state):
  - Enables drop immediately (asynchronous).
  - Outputs take their reset values; last_src = NONE, so the next request skips TURN.
- Handshake rule: req_sel is captured on accept; later changes to req_sel have no effect.

Decomposition:
- Shared package ula_pkg holds:
  - source-select constants SRC_LOGIC = 0, SRC_ARITH = 1, SRC_NOCARRY = 2, SRC_ILLEGAL = 3;
  - last_src encoding including NONE;
  - state encoding IDLE / TURN / DRIVE / HOLD;
  - default WIDTH = 8.
- Natural sub-module: ula_bus_capture. It holds the sample registers, the carry masking and the zero flag, and is loaded by a capture strobe from the FSM.

Test Plan:
- Reset, then req sel = 1 with bus driven by a model as 9'h1_00. Required: no TURN; en_arith high for 1 cycle; out_valid 2 cycles after accept; out_data = 8'h00, out_carry = 1, out_zero = 1.
- After that, req sel = 0 with bus 9'hz_A5. Required: exactly one cycle with all en_* = 0, then en_logic; out_data = 8'hA5, out_carry = 0, out_zero = 0; latency 3.
- Back-to-back sel = 2 twice, bus 9'hz_3C, out_ready held high. Required: the second request has no TURN and latency 2. A monitor checks that en_* is one-hot-or-zero every cycle.
- req sel = 3. Required: no en_* asserted; out_valid the next cycle with out_err = 1. A subsequent sel = 1 after sel = 0 history still inserts TURN.
- SETTLE_CYCLES = 3, out_ready held low 5 cycles. Required: en high 3 cycles; out_data stable and req_ready = 0 throughout HOLD; release 1 cycle after out_ready = 1.
- Assert rst_n low during DRIVE. Required: en_* = 0 immediately, out_valid = 0; the next request of a different source skips TURN.
